// File: rtl/inst_cache_sa.sv
// rtl/inst_cache_sa.sv - set-associative instruction cache with round-robin refill
// Serves one word per cycle on hit; refills a whole line from memory port A on miss.
module inst_cache_sa #(
   parameter int ADDR_WIDTH = 17,
   parameter int INST_WIDTH = 32,
   parameter int RAM_WIDTH  = 128,
   parameter int SET_BITS   = 4,
   parameter int WAYS       = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_rdy,
   input  logic                  i_flush,
   input  logic                  i_inst_cache_read_valid,
   input  logic [ADDR_WIDTH-1:0] i_inst_cache_read_addr,
   output logic                  o_inst_cache_read_ready,
   output logic                  o_inst_cache_read_done,
   output logic [INST_WIDTH-1:0] o_inst_cache_read_data,
   input  logic [RAM_WIDTH-1:0]  i_dout_a,
   output logic [ADDR_WIDTH-1:0] o_addr_a
);

   localparam int OFF    = $clog2(RAM_WIDTH / 8);
   localparam int WOFF   = $clog2(INST_WIDTH / 8);
   localparam int WORDS  = RAM_WIDTH / INST_WIDTH;
   localparam int WSEL_W = (OFF > WOFF) ? (OFF - WOFF) : 1;
   localparam int TAG_W  = ADDR_WIDTH - OFF - SET_BITS;
   localparam int SETS   = 1 << SET_BITS;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MISS_ISSUE,
      S_MISS_FILL
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [SETS-1:0]       r_valid [WAYS];
   logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
   logic [RAM_WIDTH-1:0]  r_line  [WAYS][SETS];
   logic [WAY_W-1:0]      r_ptr   [SETS];

   logic [SET_BITS-1:0]   r_idx;
   logic [TAG_W-1:0]      r_mtag;
   logic [WSEL_W-1:0]     r_wsel;

   logic                  r_done;
   logic [INST_WIDTH-1:0] r_data;
   logic [ADDR_WIDTH-1:0] r_addr_a;

   logic [SET_BITS-1:0]   w_req_idx;
   logic [TAG_W-1:0]      w_req_tag;
   logic [WSEL_W-1:0]     w_req_wsel;
   logic                  w_hit;
   logic [RAM_WIDTH-1:0]  w_hit_line;
   logic [INST_WIDTH-1:0] w_hit_word;
   logic [INST_WIDTH-1:0] w_fill_word;
   logic [WAY_W-1:0]      w_victim;
   logic                  w_evict;
   logic                  w_accept;
   logic                  w_fill;

   function automatic logic [INST_WIDTH-1:0] select_word(
      input logic [RAM_WIDTH-1:0] line,
      input logic [WSEL_W-1:0]    wsel
   );
      logic [INST_WIDTH-1:0] word;
      word = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (wsel == WSEL_W'(k)) word = line[k*INST_WIDTH +: INST_WIDTH];
      end
      return word;
   endfunction

   assign w_req_idx  = SET_BITS'(i_inst_cache_read_addr >> OFF);
   assign w_req_tag  = TAG_W'(i_inst_cache_read_addr >> (OFF + SET_BITS));
   assign w_req_wsel = WSEL_W'(i_inst_cache_read_addr >> WOFF);

   always_comb begin
      w_hit      = 1'b0;
      w_hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w][w_req_idx] && (r_tag[w][w_req_idx] == w_req_tag)) begin
            w_hit      = 1'b1;
            w_hit_line = r_line[w][w_req_idx];
         end
      end
   end

   assign w_hit_word  = select_word(w_hit_line, w_req_wsel);
   assign w_fill_word = select_word(i_dout_a, r_wsel);

   // Descending scan leaves the lowest-index invalid way; round-robin only when the set is full.
   always_comb begin
      w_victim = r_ptr[r_idx];
      w_evict  = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w][r_idx]) begin
            w_victim = WAY_W'(w);
            w_evict  = 1'b0;
         end
      end
   end

   assign w_accept = (r_state == S_IDLE) && i_inst_cache_read_valid && !i_flush;
   assign w_fill   = (r_state == S_MISS_FILL) && !i_flush;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:       if (w_accept && !w_hit) w_state_nxt = S_MISS_ISSUE;
         S_MISS_ISSUE: w_state_nxt = i_flush ? S_IDLE : S_MISS_FILL;
         S_MISS_FILL:  w_state_nxt = S_IDLE;
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else if (i_rdy) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
         for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
         r_done   <= 1'b0;
         r_data   <= '0;
         r_addr_a <= '0;
         r_idx    <= '0;
         r_mtag   <= '0;
         r_wsel   <= '0;
      end else if (i_rdy) begin
         r_done <= 1'b0;
         if (i_flush) begin
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
         end else if (w_accept) begin
            if (w_hit) begin
               r_done <= 1'b1;
               r_data <= w_hit_word;
            end else begin
               r_idx    <= w_req_idx;
               r_mtag   <= w_req_tag;
               r_wsel   <= w_req_wsel;
               r_addr_a <= {w_req_tag, w_req_idx, {OFF{1'b0}}};
            end
         end else if (w_fill) begin
            r_valid[w_victim][r_idx] <= 1'b1;
            r_done <= 1'b1;
            r_data <= w_fill_word;
            if (w_evict) begin
               r_ptr[r_idx] <= (r_ptr[r_idx] == WAY_W'(WAYS - 1)) ? '0 : r_ptr[r_idx] + 1'b1;
            end
         end
      end
   end

   // Line and tag arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_rdy && w_fill) begin
         r_line[w_victim][r_idx] <= i_dout_a;
         r_tag[w_victim][r_idx]  <= r_mtag;
      end
   end

   assign o_inst_cache_read_ready = (r_state == S_IDLE);
   assign o_inst_cache_read_done  = r_done;
   assign o_inst_cache_read_data  = r_data;
   assign o_addr_a                = r_addr_a;

endmodule

// File: tb/tb_inst_cache_sa.sv
// tb/tb_inst_cache_sa.sv - directed self-checking bench for inst_cache_sa
// Memory returns word A as 0xA5A50000 ^ A, one enabled cycle after addr_a.
module tb_inst_cache_sa;

   logic         clk;
   logic         rst;
   logic         rdy;
   logic         flush;
   logic         valid;
   logic [16:0]  addr;
   logic         ready;
   logic         done;
   logic [31:0]  data;
   logic [127:0] dout_a;
   logic [16:0]  addr_a;

   int n_cmp = 0;
   int n_bad = 0;

   inst_cache_sa dut (
      .i_clk                   (clk),
      .i_rst                   (rst),
      .i_rdy                   (rdy),
      .i_flush                 (flush),
      .i_inst_cache_read_valid (valid),
      .i_inst_cache_read_addr  (addr),
      .o_inst_cache_read_ready (ready),
      .o_inst_cache_read_done  (done),
      .o_inst_cache_read_data  (data),
      .i_dout_a                (dout_a),
      .o_addr_a                (addr_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] mem_line(input logic [16:0] a);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hA5A50000 ^ {15'd0, a + 17'(4 * k)};
      return l;
   endfunction

   always @(posedge clk) begin
      if (rdy) dout_a <= mem_line(addr_a);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_miss(input string tag, input logic [16:0] a,
                          input logic [31:0] exp_line, input logic [31:0] exp_data);
      valid = 1'b1;
      addr  = a;
      chk({tag, ".ready_before"}, {31'd0, ready}, 32'd1);
      tick;
      valid = 1'b0;
      chk({tag, ".addr_a"}, {15'd0, addr_a}, exp_line);
      chk({tag, ".ready_c1"}, {31'd0, ready}, 32'd0);
      chk({tag, ".done_c1"}, {31'd0, done}, 32'd0);
      tick;
      chk({tag, ".ready_c2"}, {31'd0, ready}, 32'd0);
      chk({tag, ".done_c2"}, {31'd0, done}, 32'd0);
      tick;
      chk({tag, ".done_c3"}, {31'd0, done}, 32'd1);
      chk({tag, ".data"}, data, exp_data);
      chk({tag, ".ready_c3"}, {31'd0, ready}, 32'd1);
      tick;
      chk({tag, ".done_c4"}, {31'd0, done}, 32'd0);
   endtask

   task automatic do_hit(input string tag, input logic [16:0] a, input logic [31:0] exp_data);
      valid = 1'b1;
      addr  = a;
      tick;
      valid = 1'b0;
      chk({tag, ".done"}, {31'd0, done}, 32'd1);
      chk({tag, ".data"}, data, exp_data);
      chk({tag, ".ready"}, {31'd0, ready}, 32'd1);
      tick;
      chk({tag, ".done_after"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      rdy   = 1'b1;
      flush = 1'b0;
      valid = 1'b0;
      addr  = '0;
      tick;
      tick;
      rst = 1'b0;
      chk("rst.ready", {31'd0, ready}, 32'd1);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.data", data, 32'h0);
      chk("rst.addr_a", {15'd0, addr_a}, 32'h0);

      do_miss("cold_104", 17'h00104, 32'h00100, 32'hA5A50104);

      valid = 1'b1;
      addr  = 17'h00108;
      tick;
      chk("b2b_108.done", {31'd0, done}, 32'd1);
      chk("b2b_108.data", data, 32'hA5A50108);
      addr = 17'h0010C;
      tick;
      valid = 1'b0;
      chk("b2b_10c.done", {31'd0, done}, 32'd1);
      chk("b2b_10c.data", data, 32'hA5A5010C);
      chk("b2b.addr_a", {15'd0, addr_a}, 32'h00100);
      tick;
      chk("b2b.done_after", {31'd0, done}, 32'd0);

      flush = 1'b1;
      tick;
      flush = 1'b0;
      do_miss("rr_000", 17'h00000, 32'h00000, 32'hA5A50000);
      do_miss("rr_100", 17'h00100, 32'h00100, 32'hA5A50100);
      do_miss("rr_200", 17'h00200, 32'h00200, 32'hA5A50200);
      do_hit("rr_hit_100", 17'h00100, 32'hA5A50100);
      do_miss("rr_000_again", 17'h00000, 32'h00000, 32'hA5A50000);
      do_hit("rr_hit_200", 17'h00200, 32'hA5A50200);
      do_miss("rr_100_again", 17'h00100, 32'h00100, 32'hA5A50100);

      do_hit("fl_hit_104", 17'h00104, 32'hA5A50104);
      flush = 1'b1;
      valid = 1'b1;
      addr  = 17'h00104;
      tick;
      flush = 1'b0;
      valid = 1'b0;
      chk("fl_prio.done", {31'd0, done}, 32'd0);
      chk("fl_prio.ready", {31'd0, ready}, 32'd1);
      do_miss("fl_104", 17'h00104, 32'h00100, 32'hA5A50104);

      valid = 1'b1;
      addr  = 17'h00204;
      tick;
      valid = 1'b0;
      chk("fl_issue.ready_c1", {31'd0, ready}, 32'd0);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("fl_issue.ready", {31'd0, ready}, 32'd1);
      chk("fl_issue.done", {31'd0, done}, 32'd0);
      tick;
      chk("fl_issue.done_later", {31'd0, done}, 32'd0);
      do_miss("fl_204", 17'h00204, 32'h00200, 32'hA5A50204);

      valid = 1'b1;
      addr  = 17'h00040;
      tick;
      valid = 1'b0;
      chk("stall.addr_a", {15'd0, addr_a}, 32'h00040);
      tick;
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("stall.addr_a_held", {15'd0, addr_a}, 32'h00040);
         chk("stall.done", {31'd0, done}, 32'd0);
         chk("stall.ready", {31'd0, ready}, 32'd0);
      end
      rdy = 1'b1;
      tick;
      chk("stall.done_end", {31'd0, done}, 32'd1);
      chk("stall.data", data, 32'hA5A50040);
      rdy = 1'b0;
      tick;
      chk("stall.done_hold", {31'd0, done}, 32'd1);
      chk("stall.data_hold", data, 32'hA5A50040);
      rdy = 1'b1;
      tick;
      chk("stall.done_clear", {31'd0, done}, 32'd0);
      chk("stall.data_keep", data, 32'hA5A50040);

      valid = 1'b1;
      addr  = 17'h00080;
      tick;
      valid = 1'b0;
      rst   = 1'b1;
      tick;
      rst = 1'b0;
      chk("rst_miss.ready", {31'd0, ready}, 32'd1);
      chk("rst_miss.done", {31'd0, done}, 32'd0);
      chk("rst_miss.addr_a", {15'd0, addr_a}, 32'h0);
      tick;
      chk("rst_miss.done_later", {31'd0, done}, 32'd0);
      do_miss("rst_040", 17'h00040, 32'h00040, 32'hA5A50040);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
